// File: rtl/nn_pkg.sv
// nn_pkg: shared widths and state type for the ECG-classifier layer blocks.
//   ACT_W   activation width (signed reg, values 0..ACT_MAX)
//   W_W     weight width (signed)
//   PROD_W  activation*weight product width
//   ACC_W   accumulator / pre-quantiser sum width
//   FRAC_SH fractional bits dropped by the quantiser
//   ACT_MAX saturation ceiling of a quantised activation
package nn_pkg;
  localparam int ACT_W   = 8;
  localparam int W_W     = 8;
  localparam int PROD_W  = 16;
  localparam int ACC_W   = 23;
  localparam int FRAC_SH = 6;
  localparam int ACT_MAX = 127;

  typedef enum logic [1:0] {IDLE, MAC, FINAL, EMIT} state_e;
endpackage

// File: rtl/nn_quant_relu.sv
// nn_quant_relu: combinational ReLU / round / saturate quantiser.
//   s  in  ACC_W  signed layer sum
//   q  out ACT_W  quantised activation 0..ACT_MAX
// Rounding adds one only when the dropped fraction is strictly above half,
// so an exact half rounds down.
module nn_quant_relu
  import nn_pkg::*;
(
  input  logic [ACC_W-1:0] s,
  output logic [ACT_W-1:0] q
);

  logic           round_up;
  logic [ACT_W:0] r;

  always_comb begin
    round_up = s[FRAC_SH-1] && (s[FRAC_SH-2:0] != '0);
    r        = {1'b0, s[FRAC_SH+ACT_W-1:FRAC_SH]} + {{ACT_W{1'b0}}, round_up};
    if (s[ACC_W-1]) begin
      q = '0;
    end else if (s[ACC_W-2:FRAC_SH+ACT_W-1] != '0) begin
      q = ACT_W'(ACT_MAX);
    end else if (r > (ACT_W+1)'(ACT_MAX)) begin
      // rounding carry out of 127 lands on 128; clamp it back
      q = ACT_W'(ACT_MAX);
    end else begin
      q = r[ACT_W-1:0];
    end
  end

endmodule

// File: rtl/fc_layer_sched.sv
// fc_layer_sched: time-multiplexed fully-connected layer on one shared MAC.
// Accepts an activation vector, then for each node fetches N_IN weights and a
// bias from external synchronous ROMs, accumulates sum(A_i*W_i)+B, quantises,
// and streams one activation per node with valid/ready.
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready/in_act   input vector handshake, element i at [8i+7:8i]
//   w_addr / w_data            weight ROM (data one cycle after address)
//   b_addr / b_data            bias ROM, b_addr = current node
//   out_valid/out_ready        result handshake, out_node/out_act held until accepted
//   busy                       not idle
//   done                       one-cycle pulse after the last node is accepted
module fc_layer_sched
  import nn_pkg::*;
#(
  parameter int N_IN    = 5,
  parameter int N_NODES = 16,
  parameter int WA_W    = 7,
  parameter int NA_W    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*ACT_W-1:0] in_act,
  output logic [WA_W-1:0]       w_addr,
  input  logic [W_W-1:0]        w_data,
  output logic [NA_W-1:0]       b_addr,
  input  logic [15:0]           b_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NA_W-1:0]       out_node,
  output logic [ACT_W-1:0]      out_act,
  output logic                  busy,
  output logic                  done
);

  localparam int K_W = $clog2(N_IN + 1);

  state_e                   state_q, state_d;
  logic [N_IN*ACT_W-1:0]    act_q;
  logic [NA_W-1:0]          node_q;
  logic [K_W-1:0]           k_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [WA_W-1:0]          w_addr_q;
  logic [ACT_W-1:0]         out_act_q;
  logic [NA_W-1:0]          out_node_q;
  logic                     done_q;

  logic signed [ACT_W-1:0]  act_sel;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext, bias_ext, s_final;
  logic [ACT_W-1:0]         q_final;
  logic                     last_k, last_node;

  // Product in MAC cycle k uses the activation paired with the weight
  // addressed in cycle k-1.
  always_comb begin
    act_sel = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (k_q == K_W'(i + 1)) act_sel = act_q[i*ACT_W +: ACT_W];
    end
    prod      = act_sel * $signed(w_data);
    prod_ext  = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    bias_ext  = {{(ACC_W-16){b_data[15]}}, b_data};
    s_final   = acc_q + bias_ext;
    last_k    = (k_q == K_W'(N_IN));
    last_node = (node_q == NA_W'(N_NODES - 1));
  end

  nn_quant_relu u_quant (
    .s (s_final),
    .q (q_final)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = MAC;
      MAC:     if (last_k) state_d = FINAL;
      FINAL:   state_d = EMIT;
      EMIT:    if (out_ready) state_d = last_node ? IDLE : MAC;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // w_addr is a register stepped once per MAC cycle: it equals node*N_IN+k in
  // cycle k, then holds; base of the next node is simply the next address.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_q      <= '0;
      node_q     <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      w_addr_q   <= '0;
      out_act_q  <= '0;
      out_node_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            act_q    <= in_act;
            node_q   <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            w_addr_q <= '0;
          end
        end
        MAC: begin
          k_q <= last_k ? '0 : k_q + 1'b1;
          if (k_q != '0) acc_q <= acc_q + prod_ext;
          if (k_q < K_W'(N_IN - 1)) w_addr_q <= w_addr_q + 1'b1;
        end
        FINAL: begin
          out_act_q  <= q_final;
          out_node_q <= node_q;
        end
        EMIT: begin
          if (out_ready) begin
            if (last_node) begin
              done_q <= 1'b1;
            end else begin
              node_q   <= node_q + 1'b1;
              acc_q    <= '0;
              k_q      <= '0;
              w_addr_q <= w_addr_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == EMIT);
  assign w_addr    = w_addr_q;
  assign b_addr    = node_q;
  assign out_node  = out_node_q;
  assign out_act   = out_act_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fc_layer_sched.sv
module tb_fc_layer_sched;

  localparam int N_IN    = 5;
  localparam int N_NODES = 16;
  localparam int NW      = N_IN * N_NODES;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [39:0] in_act = '0;
  logic [6:0]  w_addr;
  logic [7:0]  w_data = '0;
  logic [3:0]  b_addr;
  logic [15:0] b_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_node;
  logic [7:0]  out_act;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  fc_layer_sched #(.N_IN(N_IN), .N_NODES(N_NODES), .WA_W(7), .NA_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_act    (in_act),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_node  (out_node),
    .out_act   (out_act),
    .busy      (busy),
    .done      (done)
  );

  // External synchronous ROMs
  int wrom [NW];
  int brom [N_NODES];

  always @(posedge clk) begin
    w_data <= (int'(w_addr) < NW) ? 8'(wrom[w_addr]) : 8'h00;
    b_data <= 16'(brom[b_addr]);
  end

  int errors = 0;
  int checks = 0;

  typedef struct { int node; int act; } exp_t;
  exp_t expq[$];
  int   lit [N_NODES];
  logic done_exp = 1'b0;

  function automatic void check(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endfunction

  // Layer quantiser from its arithmetic definition
  function automatic int qmodel(int s);
    int r;
    if (s < 0) return 0;
    r = s / 64;
    if ((s % 64) > 32) r = r + 1;
    if (r > 127) r = 127;
    return r;
  endfunction

  function automatic void push_layer(logic [39:0] acts);
    exp_t e;
    for (int n = 0; n < N_NODES; n++) begin
      int s;
      s = brom[n];
      for (int i = 0; i < N_IN; i++) s += int'(acts[8*i +: 8]) * wrom[n*N_IN + i];
      e.node = n;
      e.act  = qmodel(s);
      expq.push_back(e);
    end
  endfunction

  function automatic void clear_lits();
    for (int n = 0; n < N_NODES; n++) lit[n] = -1;
  endfunction

  function automatic void default_rom();
    for (int n = 0; n < N_NODES; n++) begin
      for (int i = 0; i < N_IN; i++) wrom[n*N_IN + i] = ((n*37 + i*53 + 11) % 256) - 128;
      brom[n] = ((n * 1237) % 8192) - 2048;
    end
    wrom[0] = -16; wrom[1] = 14; wrom[2] = 2; wrom[3] = 62; wrom[4] = -38;
    brom[0] = 512;
  endfunction

  function automatic void fill_rom(int w, int b);
    for (int k = 0; k < NW; k++) wrom[k] = w;
    for (int n = 0; n < N_NODES; n++) brom[n] = b;
  endfunction

  // Compare process: every cycle the output port is checked against the model queue
  always @(negedge clk) begin
    if (reset) begin
      done_exp <= 1'b0;
    end else begin
      check("done", int'(done), int'(done_exp));
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          check("out_node", int'(out_node), expq[0].node);
          check("out_act", int'(out_act), expq[0].act);
        end
      end
      done_exp <= out_valid && out_ready && (expq.size() > 0) && (expq[0].node == N_NODES - 1);
      if (out_valid && out_ready && expq.size() > 0) void'(expq.pop_front());
    end
  end

  task automatic run_layer(input logic [39:0] acts, input int stall_node, input bit poke);
    int cnt;
    logic [7:0] ca;
    logic [3:0] cn;
    logic [6:0] cw;
    push_layer(acts);
    check("ready_before_vector", int'(in_ready), 1);
    in_valid = 1'b1;
    in_act   = acts;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 1) in_valid = 1'b0;
    end while (!out_valid && cnt < 40);
    check("first_latency", cnt, N_IN + 3);
    for (int n = 0; n < N_NODES; n++) begin
      cnt = 0;
      while (!out_valid && cnt < 20) begin
        @(posedge clk); #1;
        cnt++;
      end
      if (!out_valid) begin
        check("out_valid_timeout", 0, 1);
        return;
      end
      if (n == 1) check("node_pitch", cnt + 1, N_IN + 3);
      if (lit[n] >= 0) check("literal_act", int'(out_act), lit[n]);
      if (n == stall_node) begin
        out_ready = 1'b0;
        ca = out_act; cn = out_node; cw = w_addr;
        if (poke) begin
          in_valid = 1'b1;
          in_act   = 40'h7f7f7f7f7f;
        end
        repeat (10) begin
          @(posedge clk); #1;
          check("stall_valid", int'(out_valid), 1);
          check("stall_act", int'(out_act), int'(ca));
          check("stall_node", int'(out_node), int'(cn));
          check("stall_waddr", int'(w_addr), int'(cw));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      if (n == N_NODES - 1) begin
        check("done_pulse", int'(done), 1);
        check("in_ready_at_done", int'(in_ready), 1);
      end
    end
    @(posedge clk); #1;
    check("done_single", int'(done), 0);
    check("idle_not_busy", int'(busy), 0);
    check("all_outputs_seen", expq.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 1);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_out_act"}, int'(out_act), 0);
    check({tag, "_out_node"}, int'(out_node), 0);
    check({tag, "_w_addr"}, int'(w_addr), 0);
    check({tag, "_b_addr"}, int'(b_addr), 0);
  endtask

  task automatic abort_at_node2(input logic [39:0] acts);
    int cnt;
    push_layer(acts);
    in_valid = 1'b1;
    in_act   = acts;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 0;
    while (!(busy && !out_valid && b_addr == 4'd2) && cnt < 60) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("reach_node2_mac", int'(busy && !out_valid && b_addr == 4'd2), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    expq.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_outputs("abort");
    repeat (12) begin
      @(posedge clk); #1;
      check("abort_no_valid", int'(out_valid), 0);
      check("abort_no_done", int'(done), 0);
    end
  endtask

  initial begin
    clear_lits();
    default_rom();

    // Quantiser model pinned to hand-worked values
    check("model_536", qmodel(536), 8);
    check("model_96", qmodel(96), 1);
    check("model_97", qmodel(97), 2);
    check("model_8191", qmodel(8191), 127);
    check("model_80645", qmodel(80645), 127);
    check("model_neg", qmodel(-100), 0);

    // Reset held for 3 cycles with in_valid asserted
    reset    = 1'b1;
    in_valid = 1'b1;
    in_act   = 40'h0101010101;
    repeat (3) begin
      @(posedge clk); #1;
      check_reset_outputs("reset");
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("post_reset");

    // Basic accumulate, backpressure at node 3 with in_valid poked while busy
    lit[0] = 8;
    run_layer(40'h0101010101, 3, 1'b1);
    clear_lits();

    // ReLU clamp to zero
    fill_rom(-128, 0);
    lit[0] = 0;
    run_layer(40'h7f7f7f7f7f, -1, 1'b0);

    // Saturation (s = 80645)
    fill_rom(127, 0);
    lit[0] = 127;
    run_layer(40'h7f7f7f7f7f, -1, 1'b0);
    clear_lits();

    // Rounding edges driven through the bias with zero weights
    fill_rom(0, 0);
    brom[0] = 96;   lit[0] = 1;
    brom[1] = 97;   lit[1] = 2;
    brom[2] = 8191; lit[2] = 127;
    brom[3] = 32;   lit[3] = 0;
    brom[4] = 33;   lit[4] = 1;
    brom[5] = -1;   lit[5] = 0;
    brom[6] = 8160; lit[6] = 127;
    brom[7] = 8192; lit[7] = 127;
    brom[8] = 160;  lit[8] = 2;
    brom[9] = -32768;
    brom[10] = 32767;
    run_layer(40'h0505050505, -1, 1'b0);
    clear_lits();

    // Reset in the middle of node 2, then a clean layer from node 0
    default_rom();
    abort_at_node2(40'h0a3c7f0021);
    lit[0] = qmodel(512 + 10*(-38) + 60*62 + 127*2 + 0*14 + 33*(-16));
    run_layer(40'h0a3c7f0021, -1, 1'b0);
    clear_lits();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
